btn_pulse: RTL and testbench

Three-channel push-button conditioner feeding the mode selector's `button`, `u_button` and `d_button` inputs. Each raw board button is synchronised, debounced and converted into a single-cycle press pulse, so one physical press advances the mode state machine exactly once. It sits between the board pin constraints and the mode selector, in the mode selector's clock domain. An optional auto-repeat generates periodic pulses on the up and down channels while they are held.

---
 rtl/btn_pulse.sv | 116 +++++++++++
 tb/tb_btn_pulse.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/btn_pulse.sv
// Three-channel button conditioner: 2-flop synchroniser, debounce counter and
// registered one-cycle press pulse per channel. Auto-repeat on up/down via BTN_REPEAT_EN.
module btn_pulse #(
  parameter int DB_CNT       = 1_000_000,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] btn_raw,
  output logic       button,
  output logic       u_button,
  output logic       d_button,
  output logic [2:0] btn_level
);

  localparam int             DW     = $clog2(DB_CNT);
  localparam logic [DW-1:0]  DB_MAX = DW'(DB_CNT - 1);

`ifdef BTN_REPEAT_EN
  localparam int             HW          = $clog2(REPEAT_DELAY);
  localparam logic [HW-1:0]  HOLD_MAX    = HW'(REPEAT_DELAY - 1);
  // Reloading here puts the next hit of HOLD_MAX exactly REPEAT_RATE cycles away.
  localparam logic [HW-1:0]  HOLD_RELOAD = HW'(REPEAT_DELAY - REPEAT_RATE);
`endif

  logic [2:0] pulse_vec;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
      logic          s1_q, s2_q;
      logic          stable_q, stable_d;
      logic [DW-1:0] dcnt_q, dcnt_d;
      logic          pulse_q, pulse_d;
      logic          press;
      logic          rep;

      always_comb begin
        dcnt_d   = dcnt_q;
        stable_d = stable_q;
        if (s2_q == stable_q) begin
          dcnt_d = '0;
        end else if (dcnt_q == DB_MAX) begin
          stable_d = s2_q;
          dcnt_d   = '0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end

      assign press   = stable_d & ~stable_q;
      assign pulse_d = press | rep;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_q     <= 1'b0;
          s2_q     <= 1'b0;
          stable_q <= 1'b0;
          dcnt_q   <= '0;
          pulse_q  <= 1'b0;
        end else begin
          s1_q     <= btn_raw[gi];
          s2_q     <= s1_q;
          stable_q <= stable_d;
          dcnt_q   <= dcnt_d;
          pulse_q  <= pulse_d;
        end
      end

      if (gi == 0) begin : g_norep
        assign rep = 1'b0;
      end else begin : g_rep
`ifdef BTN_REPEAT_EN
        logic [HW-1:0] hold_q, hold_d;
        logic          fire;

        // Gating on stable_d stops repeats on the very edge the level drops.
        always_comb begin
          hold_d = '0;
          fire   = 1'b0;
          if (press) begin
            hold_d = '0;
          end else if (stable_d) begin
            if (hold_q == HOLD_MAX) begin
              fire   = 1'b1;
              hold_d = HOLD_RELOAD;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            hold_q <= '0;
          end else begin
            hold_q <= hold_d;
          end
        end

        assign rep = fire;
`else
        assign rep = 1'b0;
`endif
      end

      assign btn_level[gi] = stable_q;
      assign pulse_vec[gi] = pulse_q;
    end
  endgenerate

  assign button   = pulse_vec[0];
  assign u_button = pulse_vec[1];
  assign d_button = pulse_vec[2];

endmodule

// File: tb/tb_btn_pulse.sv
// Scoreboard bench for btn_pulse: a per-edge reference model pushes expected
// outputs, a negedge monitor pops and compares; directed scenarios plus random holds.
module tb_btn_pulse;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 5;
`ifdef BTN_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] btn_raw = 3'b000;
  logic       button, u_button, d_button;
  logic [2:0] btn_level;

  always #5 clk = ~clk;

  btn_pulse #(.DB_CNT(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_raw),
    .button   (button),
    .u_button (u_button),
    .d_button (d_button),
    .btn_level(btn_level)
  );

  // expected {btn_level, d, u, button} after each edge
  logic [5:0] exp_q[$];
  // directed checks handed to the monitor
  string      dn_q[$];
  int         da_q[$];
  int         de_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cnt_btn = 0, cnt_u = 0, cnt_d = 0, cnt_ud = 0;
  int cyc = 0;

  // ---------------- reference model ----------------
  bit [2:0] m_hist1, m_hist2, m_lvl;
  int       m_run[3];
  longint   m_edge;
  longint   m_press_at[3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hist1 = '0;
      m_hist2 = '0;
      m_lvl   = '0;
      m_edge  = 0;
      for (int c = 0; c < 3; c++) begin
        m_run[c]      = 0;
        m_press_at[c] = 0;
      end
      exp_q.delete();
    end else begin
      bit [2:0] seen;
      bit [2:0] pls;
      longint   t;
      seen    = m_hist2;          // raw value as seen two edges ago
      m_hist2 = m_hist1;
      m_hist1 = btn_raw;
      pls     = '0;
      for (int c = 0; c < 3; c++) begin
        if (seen[c] != m_lvl[c]) m_run[c]++;
        else m_run[c] = 0;
        if (m_run[c] == DB) begin
          m_run[c] = 0;
          m_lvl[c] = seen[c];
          if (m_lvl[c]) begin
            pls[c]        = 1'b1;
            m_press_at[c] = m_edge;
          end
        end else if (REP && c != 0 && m_lvl[c]) begin
          t = m_edge - m_press_at[c];
          if (t >= RD && ((t - RD) % RR) == 0) pls[c] = 1'b1;
        end
      end
      exp_q.push_back({m_lvl, pls});
      m_edge++;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [5:0] act;
    logic [5:0] e;
    while (dn_q.size() > 0) check(dn_q.pop_front(), da_q.pop_front(), de_q.pop_front());
    act = {btn_level, d_button, u_button, button};
    if (!rst_n) begin
      check("reset_outputs", int'(act), 0);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cycle_outputs", int'(act), int'(e));
    end
    if (rst_n && (button || u_button || d_button)) begin
      $display("cyc %0d pulse btn=%b up=%b down=%b level=%b",
               cyc, button, u_button, d_button, btn_level);
      if (button)   cnt_btn++;
      if (u_button) cnt_u++;
      if (d_button) cnt_d++;
      if (u_button && d_button) cnt_ud++;
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic dcheck(input string name, input int act, input int exp);
    dn_q.push_back(name);
    da_q.push_back(act);
    de_q.push_back(exp);
  endtask

  initial begin
    int sb, su, sd, sud;
    int hold[3];
    logic [2:0] b;

    tick(3);
    #1 rst_n = 1'b1;
    tick(4);

    // reset: buttons held, async reset mid-cycle, pulses again after release
    btn_raw = 3'b111;
    tick(8);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 dcheck("async_reset_level", int'(btn_level), 0);
    dcheck("async_reset_pulses", int'({d_button, u_button, button}), 0);
    sb = cnt_btn; su = cnt_u; sd = cnt_d;
    tick(2);
    #1 rst_n = 1'b1;
    tick(10);
    dcheck("reset_rel_button", cnt_btn - sb, 1);
    dcheck("reset_rel_up",     cnt_u - su,   1);
    dcheck("reset_rel_down",   cnt_d - sd,   1);
    btn_raw = 3'b000;
    tick(20);

    // clean press on mode channel
    sb = cnt_btn; su = cnt_u; sd = cnt_d;
    btn_raw[0] = 1'b1;
    tick(40);
    btn_raw[0] = 1'b0;
    tick(12);
    dcheck("clean_button", cnt_btn - sb, 1);
    dcheck("clean_other",  (cnt_u - su) + (cnt_d - sd), 0);

    // bounce on up channel
    su = cnt_u;
    for (int i = 0; i < 10; i++) begin
      btn_raw[1] = (i % 2 == 0);
      tick(2);
    end
    dcheck("bounce_quiet", cnt_u - su, 0);
    btn_raw[1] = 1'b1;
    tick(10);
    dcheck("bounce_final", cnt_u - su, 1);
    btn_raw[1] = 1'b0;
    tick(20);

    // simultaneous up/down
    sb = cnt_btn; su = cnt_u; sd = cnt_d; sud = cnt_ud;
    btn_raw[2:1] = 2'b11;
    tick(12);
    dcheck("simul_up",     cnt_u - su,   1);
    dcheck("simul_down",   cnt_d - sd,   1);
    dcheck("simul_same",   cnt_ud - sud, 1);
    dcheck("simul_button", cnt_btn - sb, 0);
    btn_raw[2:1] = 2'b00;
    tick(20);

    // 40-cycle hold on down, then on mode
    sd = cnt_d;
    btn_raw[2] = 1'b1;
    tick(40);
    btn_raw[2] = 1'b0;
    tick(12);
    dcheck("hold_down", cnt_d - sd, REP ? 7 : 1);
    sb = cnt_btn;
    btn_raw[0] = 1'b1;
    tick(40);
    btn_raw[0] = 1'b0;
    tick(12);
    dcheck("hold_button", cnt_btn - sb, 1);

    // random independent holds and glitches
    for (int c = 0; c < 3; c++) hold[c] = $urandom_range(1, 14);
    for (int k = 0; k < 1500; k++) begin
      b = btn_raw;
      for (int c = 0; c < 3; c++) begin
        if (hold[c] == 0) begin
          b[c]    = ~b[c];
          hold[c] = $urandom_range(1, 14);
        end
        hold[c]--;
      end
      btn_raw = b;
      tick(1);
    end
    btn_raw = 3'b000;
    tick(20);
    dcheck("final_level", int'(btn_level), 0);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
